counter_bank: RTL and testbench
===============================

// Module: counter_bank
// PURPOSE
//  - N-channel up/down counter bank; parametrised successor to the single-channel saturating up-counter.
//  - Per channel: programmable limit, saturate or wrap mode, parallel load, boundary flags, wrap pulses.
//  - Sits beside event sources (timers, pulse/stat counters); consumers read count/flags directly.
// PARAMETERS
//  WIDTH        16   counter and limit width in bits
//  CHANNELS      4   number of independent channels (>=1)
//  DEFAULT_MAX  22   per-channel limit after reset (must fit WIDTH)
//  DEFAULT_WRAP  0   per-channel mode after reset: 0=saturate, 1=wrap
// PORTS
//  clk         in   1               clock, all logic on rising edge
//  reset       in   1               synchronous, active-high
//  enable      in   CHANNELS        per-channel count enable
//  up          in   CHANNELS        per-channel direction: 1=increment, 0=decrement
//  load        in   CHANNELS        per-channel parallel load strobe
//  load_value  in   CHANNELS*WIDTH  load data, channel i at [i*WIDTH +: WIDTH]
//  cfg_we      in   1               config write strobe
//  cfg_sel     in   max(1,$clog2(CHANNELS))  channel addressed by cfg_we
//  cfg_max     in   WIDTH           new limit for channel cfg_sel
//  cfg_wrap    in   1               new mode for channel cfg_sel
//  count       out  CHANNELS*WIDTH  counter values, registered
//  at_max      out  CHANNELS        count == limit, registered
//  at_zero     out  CHANNELS        count == 0, registered
//  wrapped     out  CHANNELS        1-cycle pulse: channel wrapped this cycle, registered
// BEHAVIOUR
//  - Reset: count=0, at_zero=all 1, at_max=0 (1 if DEFAULT_MAX==0), wrapped=0, limit=DEFAULT_MAX, mode=DEFAULT_WRAP.
//  - All outputs registered; flags always reflect the count/limit present on the same cycle's outputs.
//  - Per-channel priority each cycle: reset > load > clamp > enable > hold.
//  - load: count <= min(load_value, limit); wrapped=0; up/enable ignored that cycle.
//  - clamp: if count > limit (after limit shrink), count <= limit; enable ignored that cycle.
//  - enable & up: count<limit -> count+1; count==limit -> saturate: hold; wrap: count<=0, wrapped=1.
//  - enable & !up: count>0 -> count-1; count==0 -> saturate: hold; wrap: count<=limit, wrapped=1.
//  - limit==0: wrap mode toggles nothing (0->0) but still pulses wrapped on every enabled cycle.
//  - Arithmetic in WIDTH bits only; no carry out; limit==2^WIDTH-1 wrap equals natural rollover.
//  - cfg_we: limit/mode of cfg_sel updated at the clock edge; take effect for counting next cycle.
//    cfg_sel >= CHANNELS: write ignored. Concurrent load/enable on that channel use OLD limit/mode this cycle.
//    Shrinking limit below count: clamp fires the following cycle (one cycle of count > limit allowed).
//  - wrapped deasserts the cycle after any non-wrapping cycle; never asserted with load or reset.
//  - Channels fully independent; simultaneous events on different channels never interact.
//  - Invariant (formal): after first reset, count <= limit except the single cycle following a limit shrink;
//    at_max/at_zero consistent with count. Cover: each channel reaching limit and wrapping.
// STRUCTURE
//  - Package counter_pkg: MODE_SATURATE/MODE_WRAP constants, channel-slice helper function.
//  - Sub-module counter_channel: one channel (count, limit, mode, flags, wrap pulse) with cfg write
//    enable already decoded; counter_bank = generate loop of CHANNELS instances + cfg_sel decoder.
// TESTING
//  - Reset, WIDTH=16, defaults: enable[0]=up[0]=1 for 30 cycles -> count0 saturates at 22, at_max=1, wrapped=0.
//  - cfg ch1 wrap, limit 5; count up 7 cycles -> 1,2,3,4,5,0,1; wrapped pulses once on 5->0.
//  - ch2 wrap, count down from 0 with limit 5 -> 5, wrapped=1; saturate mode at 0 -> holds 0, at_zero=1.
//  - load ch3 value 40 with limit 22 -> count3=22, at_max=1; load and enable same cycle -> load wins.
//  - ch0 at 20, cfg_max=10 -> next cycle count still 20, following cycle 10 with at_max=1.
//  - Mid-operation reset while ch1 wrapping and cfg_we active -> all counts 0, limits 22, wrapped=0.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared mode constants and slice helper for the counter bank
package counter_pkg;

  localparam logic MODE_SATURATE = 1'b0;
  localparam logic MODE_WRAP     = 1'b1;

  // LSB position of channel ch inside a flattened CHANNELS*width bus
  function automatic int chan_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/counter_channel.sv
// rtl/counter_channel.sv - one up/down counter channel with limit, mode, flags and wrap pulse
module counter_channel
  import counter_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int DEFAULT_MAX  = 22,
  parameter bit DEFAULT_WRAP = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_max,
  input  logic             cfg_wrap,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_zero,
  output logic             wrapped
);

  localparam logic [WIDTH-1:0] RESET_MAX  = WIDTH'(DEFAULT_MAX);
  localparam logic             RESET_WRAP = DEFAULT_WRAP;
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO       = '0;

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             mode_q, mode_d;
  logic             at_max_q, at_max_d;
  logic             at_zero_q, at_zero_d;
  logic             wrapped_q, wrapped_d;

  // Next state: load > clamp > enable > hold; counting always uses the current (old) limit/mode
  always_comb begin
    count_d   = count_q;
    limit_d   = limit_q;
    mode_d    = mode_q;
    wrapped_d = 1'b0;

    if (cfg_we) begin
      limit_d = cfg_max;
      mode_d  = cfg_wrap;
    end

    if (load) begin
      count_d = (load_value > limit_q) ? limit_q : load_value;
    end else if (count_q > limit_q) begin
      // limit was shrunk last cycle; pull the count back inside the range
      count_d = limit_q;
    end else if (enable) begin
      if (up) begin
        if (count_q != limit_q) begin
          count_d = count_q + ONE;
        end else if (mode_q == MODE_WRAP) begin
          count_d   = ZERO;
          wrapped_d = 1'b1;
        end
      end else begin
        if (count_q != ZERO) begin
          count_d = count_q - ONE;
        end else if (mode_q == MODE_WRAP) begin
          count_d   = limit_q;
          wrapped_d = 1'b1;
        end
      end
    end

    // flags are computed from the values that will be registered alongside them
    at_max_d  = (count_d == limit_d);
    at_zero_d = (count_d == ZERO);
  end

  // State registers with synchronous reset to the default limit/mode
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= ZERO;
      limit_q   <= RESET_MAX;
      mode_q    <= RESET_WRAP;
      at_max_q  <= (RESET_MAX == ZERO);
      at_zero_q <= 1'b1;
      wrapped_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      limit_q   <= limit_d;
      mode_q    <= mode_d;
      at_max_q  <= at_max_d;
      at_zero_q <= at_zero_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign count   = count_q;
  assign at_max  = at_max_q;
  assign at_zero = at_zero_q;
  assign wrapped = wrapped_q;

endmodule

// File: rtl/counter_bank.sv
// rtl/counter_bank.sv - N-channel up/down counter bank with per-channel limit and mode
module counter_bank
  import counter_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int CHANNELS     = 4,
  parameter int DEFAULT_MAX  = 22,
  parameter bit DEFAULT_WRAP = 1'b0
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [CHANNELS-1:0]                           enable,
  input  logic [CHANNELS-1:0]                           up,
  input  logic [CHANNELS-1:0]                           load,
  input  logic [CHANNELS*WIDTH-1:0]                     load_value,
  input  logic                                          cfg_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_sel,
  input  logic [WIDTH-1:0]                              cfg_max,
  input  logic                                          cfg_wrap,
  output logic [CHANNELS*WIDTH-1:0]                     count,
  output logic [CHANNELS-1:0]                           at_max,
  output logic [CHANNELS-1:0]                           at_zero,
  output logic [CHANNELS-1:0]                           wrapped
);

  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] cfg_we_ch;

  // Decode the config write to a single channel; out-of-range selects match nothing
  always_comb begin
    cfg_we_ch = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cfg_we_ch[i] = cfg_we && (cfg_sel == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    counter_channel #(
      .WIDTH        (WIDTH),
      .DEFAULT_MAX  (DEFAULT_MAX),
      .DEFAULT_WRAP (DEFAULT_WRAP)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable[g]),
      .up         (up[g]),
      .load       (load[g]),
      .load_value (load_value[chan_lsb(g, WIDTH) +: WIDTH]),
      .cfg_we     (cfg_we_ch[g]),
      .cfg_max    (cfg_max),
      .cfg_wrap   (cfg_wrap),
      .count      (count[chan_lsb(g, WIDTH) +: WIDTH]),
      .at_max     (at_max[g]),
      .at_zero    (at_zero[g]),
      .wrapped    (wrapped[g])
    );
  end

endmodule

// File: tb/tb_counter_bank.sv
// tb/tb_counter_bank.sv - scoreboard bench for counter_bank against a modular-arithmetic model
module tb_counter_bank;

  localparam int W    = 16;
  localparam int CH   = 4;
  localparam int DMAX = 22;

  logic              clk = 1'b0;
  logic              reset;
  logic [CH-1:0]     enable, up, load;
  logic [CH*W-1:0]   load_value;
  logic              cfg_we;
  logic [1:0]        cfg_sel;
  logic [W-1:0]      cfg_max;
  logic              cfg_wrap;
  logic [CH*W-1:0]   count;
  logic [CH-1:0]     at_max, at_zero, wrapped;

  always #5 clk = ~clk;

  counter_bank #(
    .WIDTH        (W),
    .CHANNELS     (CH),
    .DEFAULT_MAX  (DMAX),
    .DEFAULT_WRAP (1'b0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .up         (up),
    .load       (load),
    .load_value (load_value),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_max    (cfg_max),
    .cfg_wrap   (cfg_wrap),
    .count      (count),
    .at_max     (at_max),
    .at_zero    (at_zero),
    .wrapped    (wrapped)
  );

  typedef struct packed {
    logic [CH*W-1:0] count;
    logic [CH-1:0]   at_max;
    logic [CH-1:0]   at_zero;
    logic [CH-1:0]   wrapped;
    logic [7:0]      phase;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  int   m_cnt [CH];
  int   m_lim [CH];
  bit   m_wrap[CH];
  logic [7:0] phase = 8'd0;

  logic            n_reset;
  logic [CH-1:0]   n_en, n_up, n_ld;
  logic [CH*W-1:0] n_lv;
  logic            n_cwe;
  logic [1:0]      n_sel;
  logic [W-1:0]    n_cmax;
  logic            n_cwrap;

  task automatic clear_next();
    n_reset = 1'b0; n_en = '0; n_up = '0; n_ld = '0; n_lv = '0;
    n_cwe = 1'b0; n_sel = '0; n_cmax = '0; n_cwrap = 1'b0;
  endtask

  // Drive one cycle of stimulus, advance the model and queue the expected post-edge outputs
  task automatic step();
    exp_t e;
    int   lv, lim_old, c;
    bit   w;
    reset = n_reset; enable = n_en; up = n_up; load = n_ld; load_value = n_lv;
    cfg_we = n_cwe; cfg_sel = n_sel; cfg_max = n_cmax; cfg_wrap = n_cwrap;
    e = '0;
    for (int i = 0; i < CH; i++) begin
      w = 1'b0;
      if (n_reset) begin
        m_cnt[i] = 0; m_lim[i] = DMAX; m_wrap[i] = 1'b0;
      end else begin
        lim_old = m_lim[i];
        c = m_cnt[i];
        lv = int'(n_lv[i*W +: W]);
        if (n_ld[i]) c = (lv < lim_old) ? lv : lim_old;
        else if (c > lim_old) c = lim_old;
        else if (n_en[i]) begin
          if (m_wrap[i]) begin
            // wrap mode is counting modulo (limit + 1)
            if (n_up[i]) begin w = (c == lim_old); c = (c + 1) % (lim_old + 1); end
            else begin w = (c == 0); c = (c + lim_old) % (lim_old + 1); end
          end else begin
            if (n_up[i]) c = (c + 1 > lim_old) ? lim_old : c + 1;
            else c = (c > 0) ? c - 1 : 0;
          end
        end
        m_cnt[i] = c;
        if (n_cwe && int'(n_sel) == i) begin
          m_lim[i] = int'(n_cmax); m_wrap[i] = n_cwrap;
        end
      end
      e.count[i*W +: W] = W'(m_cnt[i]);
      e.at_max[i]  = (m_cnt[i] == m_lim[i]);
      e.at_zero[i] = (m_cnt[i] == 0);
      e.wrapped[i] = w;
    end
    e.phase = phase;
    sb.push_back(e);
    clear_next();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [7:0] ph, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL phase%0d %s got=%h want=%h", ph, name, got, want);
    end
  endtask

  // Monitor: outputs are presented every cycle, so pop one expectation per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("count",   e.phase, 64'(count),   64'(e.count));
        chk("at_max",  e.phase, 64'(at_max),  64'(e.at_max));
        chk("at_zero", e.phase, 64'(at_zero), 64'(e.at_zero));
        chk("wrapped", e.phase, 64'(wrapped), 64'(e.wrapped));
      end
    end
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL timeout got=running want=done");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    clear_next();
    reset = 1'b1; enable = '0; up = '0; load = '0; load_value = '0;
    cfg_we = 1'b0; cfg_sel = '0; cfg_max = '0; cfg_wrap = 1'b0;
    @(negedge clk);

    phase = 8'd0;
    repeat (2) begin n_reset = 1'b1; step(); end

    phase = 8'd1;
    repeat (30) begin n_en = 4'b0001; n_up = 4'b0001; step(); end

    phase = 8'd2;
    n_cwe = 1'b1; n_sel = 2'd1; n_cmax = 16'd5; n_cwrap = 1'b1; step();
    repeat (7) begin n_en = 4'b0010; n_up = 4'b0010; step(); end

    phase = 8'd3;
    n_cwe = 1'b1; n_sel = 2'd2; n_cmax = 16'd5; n_cwrap = 1'b1; step();
    n_en = 4'b0100; step();
    step();
    repeat (2) begin n_en = 4'b1000; step(); end

    phase = 8'd4;
    n_ld = 4'b1000; n_lv[3*W +: W] = 16'd40; step();
    n_ld = 4'b1000; n_lv[3*W +: W] = 16'd7; n_en = 4'b1000; n_up = 4'b1000; step();

    phase = 8'd5;
    n_ld = 4'b0001; n_lv[0 +: W] = 16'd20; step();
    n_cwe = 1'b1; n_sel = 2'd0; n_cmax = 16'd10; n_cwrap = 1'b0; step();
    step();
    step();

    phase = 8'd6;
    n_cwe = 1'b1; n_sel = 2'd2; n_cmax = 16'd0; n_cwrap = 1'b1; step();
    repeat (3) begin n_en = 4'b0100; n_up = 4'b0100; step(); end
    n_en = 4'b0100; step();

    phase = 8'd7;
    n_cwe = 1'b1; n_sel = 2'd1; n_cmax = 16'hffff; n_cwrap = 1'b1; step();
    n_ld = 4'b0010; n_lv[W +: W] = 16'hfffe; step();
    repeat (2) begin n_en = 4'b0010; n_up = 4'b0010; step(); end

    phase = 8'd8;
    n_cwe = 1'b1; n_sel = 2'd1; n_cmax = 16'd3; n_cwrap = 1'b1; step();
    repeat (4) begin n_en = 4'b0010; n_up = 4'b0010; step(); end
    n_reset = 1'b1; n_en = 4'b1111; n_up = 4'b1111;
    n_cwe = 1'b1; n_sel = 2'd1; n_cmax = 16'd2; n_cwrap = 1'b1; step();
    step();

    phase = 8'd9;
    repeat (500) begin
      n_en = CH'($urandom);
      n_up = CH'($urandom);
      for (int i = 0; i < CH; i++) begin
        n_ld[i] = ($urandom_range(0, 15) == 0);
        n_lv[i*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 40));
      end
      if ($urandom_range(0, 9) == 0) begin
        n_cwe = 1'b1;
        n_sel = 2'($urandom);
        case ($urandom_range(0, 5))
          0:       n_cmax = 16'd0;
          1:       n_cmax = 16'hffff;
          default: n_cmax = W'($urandom_range(0, 30));
        endcase
        n_cwrap = 1'($urandom);
      end
      n_reset = ($urandom_range(0, 199) == 0);
      step();
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 8'd10, 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
